plugboard_ctrl: RTL

Configuration controller and lookup server for the Enigma plugboard swap table. It holds a 26-entry reciprocal letter map (letter codes 0–25, A=0). The map is programmed through a valid/ready command port supporting add-pair, remove-pair and clear-all, with every command checked before it is applied. The encrypt path reads the map through a separate stalling lookup port, so it never observes a half-written pair.

---
 rtl/plugboard_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/plugboard_ctrl.sv
// -----------------------------------------------------------------------------
// plugboard_ctrl
//
// Configuration controller and lookup server for the Enigma plugboard swap
// table. Holds a reciprocal letter map (map[i] is the partner of letter i).
// A valid/ready command port adds pairs, removes pairs and clears the whole
// table. Every command is validated before the map is touched. A separate
// lookup port serves the encrypt path. It is stalled while a pair is
// half-written, so it only ever sees a reciprocal map.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_valid/cfg_ready   command handshake (ready only while idle)
//   cfg_op                00 add, 01 remove, 10 clear, 11 illegal
//   cfg_a, cfg_b          letter operands (cfg_b used by add only)
//   cfg_done, cfg_err     one-cycle completion / rejection pulses
//   err_code              reason for the last rejection, held until next one
//   lk_valid/lk_ready     lookup handshake
//   lk_in                 letter to map
//   lk_out_valid, lk_out  registered lookup result
//   pair_count            number of installed pairs (0..13)
// -----------------------------------------------------------------------------
module plugboard_ctrl #(
    parameter int LETTERS = 26,
    parameter int W       = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [1:0]   cfg_op,
    input  logic [W-1:0] cfg_a,
    input  logic [W-1:0] cfg_b,
    output logic         cfg_done,
    output logic         cfg_err,
    output logic [1:0]   err_code,
    input  logic         lk_valid,
    output logic         lk_ready,
    input  logic [W-1:0] lk_in,
    output logic         lk_out_valid,
    output logic [W-1:0] lk_out,
    output logic [3:0]   pair_count
);

    localparam int             IW       = $clog2(LETTERS);
    localparam logic [W-1:0]   LAST     = W'(LETTERS - 1);
    localparam logic [IW-1:0]  LAST_IDX = IW'(LETTERS - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_REM = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [1:0] E_OP    = 2'd0;
    localparam logic [1:0] E_RANGE = 2'd1;
    localparam logic [1:0] E_SAME  = 2'd2;
    localparam logic [1:0] E_CONF  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WR_A,
        WR_B,
        CLEAR,
        RESP
    } state_t;

    state_t        state;
    logic [W-1:0]  map [LETTERS];
    logic [1:0]    op_l;
    logic [W-1:0]  a_l;
    logic [W-1:0]  b_l;
    logic [W-1:0]  p_l;
    logic [IW-1:0] clr_idx;
    logic          chk_err;
    logic [1:0]    chk_code;
    logic          lk_acc;

    // Out-of-range codes map to themselves, which gives the lookup
    // pass-through and keeps the checker from indexing past the table.
    function automatic logic [W-1:0] map_rd(input logic [W-1:0] code);
        if (code > LAST)
            return code;
        else
            return map[code[IW-1:0]];
    endfunction

    assign cfg_ready = (state == IDLE);
    // Stall lookups only while the map may be mid-update.
    assign lk_ready  = !((state == WR_A) || (state == WR_B) || (state == CLEAR));
    assign lk_acc    = lk_valid && lk_ready;

    // Command validation, evaluated against the latched command in CHECK.
    always_comb begin
        chk_err  = 1'b0;
        chk_code = E_OP;
        if (op_l == OP_ILL) begin
            chk_err  = 1'b1;
            chk_code = E_OP;
        end else if ((a_l > LAST) || ((op_l == OP_ADD) && (b_l > LAST))) begin
            chk_err  = 1'b1;
            chk_code = E_RANGE;
        end else if ((op_l == OP_ADD) && (a_l == b_l)) begin
            chk_err  = 1'b1;
            chk_code = E_SAME;
        end else if ((op_l == OP_ADD) &&
                     ((map_rd(a_l) != a_l) || (map_rd(b_l) != b_l))) begin
            chk_err  = 1'b1;
            chk_code = E_CONF;
        end else if ((op_l == OP_REM) && (map_rd(a_l) == a_l)) begin
            chk_err  = 1'b1;
            chk_code = E_CONF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            op_l         <= OP_ADD;
            a_l          <= '0;
            b_l          <= '0;
            p_l          <= '0;
            clr_idx      <= '0;
            cfg_done     <= 1'b0;
            cfg_err      <= 1'b0;
            err_code     <= 2'd0;
            pair_count   <= 4'd0;
            lk_out_valid <= 1'b0;
            lk_out       <= '0;
            for (int i = 0; i < LETTERS; i++)
                map[i] <= W'(i);
        end else begin
            cfg_done     <= 1'b0;
            cfg_err      <= 1'b0;
            lk_out_valid <= lk_acc;
            // Reads the map as it stands before this edge's write.
            if (lk_acc)
                lk_out <= map_rd(lk_in);

            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        op_l  <= cfg_op;
                        a_l   <= cfg_a;
                        b_l   <= cfg_b;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (chk_err) begin
                        cfg_err  <= 1'b1;
                        err_code <= chk_code;
                        state    <= RESP;
                    end else if (op_l == OP_ADD) begin
                        state <= WR_A;
                    end else if (op_l == OP_REM) begin
                        // Remember the partner before map[a] is overwritten.
                        p_l   <= map_rd(a_l);
                        state <= WR_A;
                    end else begin
                        clr_idx <= '0;
                        state   <= CLEAR;
                    end
                end
                WR_A: begin
                    map[a_l[IW-1:0]] <= (op_l == OP_ADD) ? b_l : a_l;
                    state            <= WR_B;
                end
                WR_B: begin
                    if (op_l == OP_ADD) begin
                        map[b_l[IW-1:0]] <= a_l;
                        pair_count       <= pair_count + 4'd1;
                    end else begin
                        map[p_l[IW-1:0]] <= p_l;
                        pair_count       <= pair_count - 4'd1;
                    end
                    cfg_done <= 1'b1;
                    state    <= RESP;
                end
                CLEAR: begin
                    map[clr_idx] <= W'(clr_idx);
                    if (clr_idx == LAST_IDX) begin
                        pair_count <= 4'd0;
                        cfg_done   <= 1'b1;
                        state      <= RESP;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
